// File: rtl/demux4_rr_dispatch_pkg.sv
// Shared constants and types for the 4-channel round-robin dispatcher.
// Channel indices are 2 bits wide so pointer arithmetic wraps modulo 4 on its own.
package demux4_rr_dispatch_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int NUM_CH        = 4;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mode_e;

  typedef logic [1:0] ch_t;

endpackage

// File: rtl/demux4_rr_dispatch_demux.sv
// 1-to-4 data demultiplexer: routes the input word to the selected output.
// The outputs that are not selected are driven to zero.
module demux4to1_16bit
  import demux4_rr_dispatch_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4
);

  always_comb begin
    out1 = '0;
    out2 = '0;
    out3 = '0;
    out4 = '0;
    case (sel)
      2'd0:    out1 = in;
      2'd1:    out2 = in;
      2'd2:    out3 = in;
      default: out4 = in;
    endcase
  end

endmodule

// File: rtl/demux4_rr_dispatch.sv
// Dispatches a stream of words into four one-word channel slots, either
// round-robin over empty slots or pinned to a configured channel.
module demux4_rr_dispatch
  import demux4_rr_dispatch_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [1:0]        cfg_sel,
  output logic [WIDTH-1:0]  out_data0,
  output logic [WIDTH-1:0]  out_data1,
  output logic [WIDTH-1:0]  out_data2,
  output logic [WIDTH-1:0]  out_data3,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [1:0]        last_sel
);

  ch_t              ptr;
  ch_t              rr_target;
  logic             rr_found;
  logic [2*NUM_CH-1:0] rotated;
  ch_t              target;
  logic             accept;
  logic [NUM_CH-1:0] load_en;
  logic [WIDTH-1:0] fan [NUM_CH];
  logic [WIDTH-1:0] slot_data [NUM_CH];

  // Rotate occupancy so the search starts at ptr; a draining slot still reads
  // as full, so there is no same-cycle bypass. Lowest rotated index wins.
  always_comb begin
    rotated   = {out_valid, out_valid} >> ptr;
    rr_found  = 1'b0;
    rr_target = ptr;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (!rotated[k]) begin
        rr_found  = 1'b1;
        rr_target = ptr + ch_t'(k);
      end
    end
  end

  always_comb begin
    if (mode_e'(mode) == MODE_FIXED) begin
      target   = cfg_sel;
      in_ready = !out_valid[cfg_sel];
    end else begin
      target   = rr_target;
      in_ready = rr_found;
    end
  end

  assign accept = in_valid && in_ready;

  demux4to1_16bit #(
    .WIDTH(WIDTH)
  ) u_fanout (
    .in  (in_data),
    .sel (target),
    .out1(fan[0]),
    .out2(fan[1]),
    .out3(fan[2]),
    .out4(fan[3])
  );

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      load_en[i] = accept && (target == ch_t'(i));
    end
  end

  // A slot never loads while full, so load and drain of one slot cannot collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= '0;
      ptr       <= '0;
      last_sel  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load_en[i]) begin
          out_valid[i] <= 1'b1;
          slot_data[i] <= fan[i];
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
      if (accept) begin
        last_sel <= target;
        if (mode_e'(mode) == MODE_RR) begin
          ptr <= target + 2'd1;
        end
      end
    end
  end

  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];

endmodule

// File: tb/tb_demux4_rr_dispatch.sv
// Randomised and directed bench for demux4_rr_dispatch with a per-channel
// scoreboard fed by a behavioural model and drained by an independent monitor.
module tb_demux4_rr_dispatch;

  logic        clk;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [1:0]  cfg_sel;
  logic [15:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  last_sel;

  logic [15:0] dout [4];

  int n_compared   = 0;
  int n_mismatched = 0;

  // Behavioural model state: occupancy, pointer, last target and expected words.
  bit          m_full [4];
  int          m_ptr;
  int          m_last;
  logic [15:0] exp_q [4][$];

  demux4_rr_dispatch #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .cfg_sel  (cfg_sel),
    .out_data0(out_data0),
    .out_data1(out_data1),
    .out_data2(out_data2),
    .out_data3(out_data3),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .last_sel (last_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    dout[0] = out_data0;
    dout[1] = out_data1;
    dout[2] = out_data2;
    dout[3] = out_data3;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [3:0] model_valid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_full[i];
    return v;
  endfunction

  // Drives one cycle of inputs, checks the visible state against the model,
  // then advances the model to what the coming edge should produce.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [3:0] rdy,
                               input logic m, input logic [1:0] cs, input logic rst);
    bit exp_ready;
    int tgt;
    @(negedge clk);
    reset     = rst;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    mode      = m;
    cfg_sel   = cs;
    #1;
    tgt = -1;
    if (m) begin
      tgt = int'(cs);
      exp_ready = !m_full[tgt];
    end else begin
      exp_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (!exp_ready && !m_full[(m_ptr + k) % 4]) begin
          exp_ready = 1'b1;
          tgt = (m_ptr + k) % 4;
        end
      end
    end
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    checkOutput("out_valid", 32'(out_valid), 32'(model_valid()));
    checkOutput("last_sel", 32'(last_sel), 32'(m_last));
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_full[i] = 1'b0;
        exp_q[i].delete();
      end
      m_ptr  = 0;
      m_last = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (rdy[i]) m_full[i] = 1'b0;
      end
      if (v && exp_ready) begin
        m_full[tgt] = 1'b1;
        exp_q[tgt].push_back(d);
        m_last = tgt;
        if (!m) m_ptr = (tgt + 1) % 4;
      end
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 16'h0, 4'b0000, 1'b0, 2'd0, 1'b0);
  endtask

  // Monitor: every word a consumer takes must be the oldest expected for that channel.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        for (int i = 0; i < 4; i++) begin
          if (out_valid[i] && out_ready[i]) begin
            if (exp_q[i].size() == 0) begin
              checkOutput($sformatf("unexpected_word_ch%0d", i), 32'(dout[i]), 32'hFFFF_FFFF);
            end else begin
              checkOutput($sformatf("data_ch%0d", i), 32'(dout[i]), 32'(exp_q[i].pop_front()));
            end
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = '0; mode = 1'b0; cfg_sel = '0;
    for (int i = 0; i < 4; i++) m_full[i] = 1'b0;
    m_ptr = 0;
    m_last = 0;
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 4'b0000, 1'b0, 2'd0, 1'b1);
    applyStimulus(1'b0, 16'h0, 4'b0000, 1'b0, 2'd0, 1'b1);

    // Four back-to-back words fill ch0..ch3 in order.
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 16'(i), 4'b0000, 1'b0, 2'd0, 1'b0);
    idle();
    checkOutput("fill_in_ready", 32'(in_ready), 32'h0);
    checkOutput("fill_last_sel", 32'(last_sel), 32'h3);
    checkOutput("fill_valid", 32'(out_valid), 32'hF);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("fill_data%0d", i), 32'(dout[i]), 32'(i + 1));

    // Held word waits for slot 2 to drain, then lands there; ptr moves to 3.
    applyStimulus(1'b1, 16'hAAAA, 4'b0100, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 16'hAAAA, 4'b0000, 1'b0, 2'd0, 1'b0);
    idle();
    checkOutput("hold_data2", 32'(out_data2), 32'hAAAA);
    checkOutput("hold_last_sel", 32'(last_sel), 32'h2);
    applyStimulus(1'b0, 16'h0, 4'b1001, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 16'h3333, 4'b0000, 1'b0, 2'd0, 1'b0);
    idle();
    checkOutput("ptr3_last_sel", 32'(last_sel), 32'h3);
    checkOutput("ptr3_data3", 32'(out_data3), 32'h3333);

    // Draining slot 1 is not bypassed: the word goes to ch2.
    applyStimulus(1'b0, 16'h0, 4'b0000, 1'b0, 2'd0, 1'b1);
    applyStimulus(1'b1, 16'h1111, 4'b0000, 1'b1, 2'd1, 1'b0);
    applyStimulus(1'b1, 16'h2222, 4'b0000, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 16'h5555, 4'b0010, 1'b0, 2'd0, 1'b0);
    idle();
    checkOutput("nobypass_valid", 32'(out_valid), 32'h5);
    checkOutput("nobypass_data2", 32'(out_data2), 32'h5555);
    checkOutput("nobypass_last_sel", 32'(last_sel), 32'h2);

    // Fixed mode follows cfg_sel immediately and leaves ptr alone.
    applyStimulus(1'b0, 16'h0, 4'b0000, 1'b0, 2'd0, 1'b1);
    applyStimulus(1'b1, 16'h6666, 4'b0000, 1'b1, 2'd2, 1'b0);
    applyStimulus(1'b1, 16'h7777, 4'b0000, 1'b1, 2'd2, 1'b0);
    checkOutput("fixed_blocked", 32'(in_ready), 32'h0);
    applyStimulus(1'b1, 16'h7777, 4'b0000, 1'b1, 2'd0, 1'b0);
    checkOutput("fixed_switch", 32'(in_ready), 32'h1);
    idle();
    checkOutput("fixed_valid", 32'(out_valid), 32'h5);
    checkOutput("fixed_data0", 32'(out_data0), 32'h7777);
    applyStimulus(1'b0, 16'h0, 4'b0001, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 16'h8888, 4'b0000, 1'b0, 2'd0, 1'b0);
    idle();
    checkOutput("fixed_ptr_kept", 32'(last_sel), 32'h0);

    // Reset with every slot full discards them without a drain.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'hC000 + 16'(i), 4'b0000, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 16'hDEAD, 4'b1111, 1'b0, 2'd0, 1'b1);
    idle();
    checkOutput("rst_valid", 32'(out_valid), 32'h0);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("rst_data%0d", i), 32'(dout[i]), 32'h0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
    applyStimulus(1'b1, 16'h9999, 4'b0000, 1'b0, 2'd0, 1'b0);
    idle();
    checkOutput("rst_first_ch", 32'(last_sel), 32'h0);
    checkOutput("rst_first_data", 32'(out_data0), 32'h9999);

    // Random round-robin traffic.
    for (int c = 0; c < 10000; c++) begin
      applyStimulus($urandom_range(0, 99) < 65, 16'($urandom()), 4'($urandom_range(0, 15)),
                    1'b0, 2'd0, 1'b0);
    end
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 16'h0, 4'b1111, 1'b0, 2'd0, 1'b0);
    idle();
    for (int i = 0; i < 4; i++) checkOutput($sformatf("leftover_ch%0d", i), 32'(exp_q[i].size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
